// File: rtl/ec_eng_seq_ctrl.sv
// ec_eng_seq_ctrl
// Sequences NUM_ENG erasure-coding engines, run in lock-step, through a
// multi-packet encode job. For each packet the controller:
//   1. pulses the engine reset,
//   2. fetches cfg_k bitmatrix columns one at a time and gates engine
//      calculation for each column,
//   3. drains the engines and commits the packet to the output buffer.
// It also provides abort, a done pulse and a sticky configuration-error flag.
//
// Optional feature macro: EC_SEQ_PERF_CNT_EN
//   defined   : busy_cycles counts the cycles with busy=1. It saturates at
//               2^32-1 and clears on each accepted start.
//   undefined : busy_cycles is tied to 0.
//
// Ports
//   clk, rstn                        clock, async active-low reset
//   start, abort                     job control (start is sampled in IDLE only)
//   cfg_k, cfg_num_pkts, cfg_bm_base job configuration, latched on start
//   eng_empty, eng_new_col_req       engine status
//   bm_mem_rd_*                      bitmatrix memory read port
//   bm_col_data_out/_val             column register broadcast to the engines
//   eng_rstn_o                       engine reset, active-low
//   cntrl_inbuff_rd_en               input buffer read strobe
//   cntrl_eng_calc_en                engine calculate enable
//   cntrl_outbuff_wr_en              output buffer write strobe
//   busy, done, cfg_err              job status
//   busy_cycles                      performance counter
//
// state   | meaning
// IDLE    | waiting for start; config is checked here
// ENG_RST | engine reset pulse for the current packet
// FETCH   | one-cycle bitmatrix read request for col_idx
// WAIT_BM | waiting for read data; captured into the column register
// CALC    | engines calculating; leave on eng_new_col_req
// DRAIN   | waiting until all engines report empty
// WRITE   | one-cycle output buffer commit
// DONE    | one-cycle done pulse
module ec_eng_seq_ctrl #(
  parameter int NUM_ENG       = 2,
  parameter int K_MAX         = 8,
  parameter int BM_COL_W      = 64,
  parameter int BM_MEM_ADDR_W = 8,
  parameter int PKT_CNT_W     = 16,
  localparam int K_W          = $clog2(K_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [K_W-1:0]           cfg_k,
  input  logic [PKT_CNT_W-1:0]     cfg_num_pkts,
  input  logic [BM_MEM_ADDR_W-1:0] cfg_bm_base,
  input  logic [NUM_ENG-1:0]       eng_empty,
  input  logic                     eng_new_col_req,
  input  logic [BM_COL_W-1:0]      bm_mem_rd_data,
  input  logic                     bm_mem_rd_data_val,
  output logic                     bm_mem_rd_rq,
  output logic [BM_MEM_ADDR_W-1:0] bm_mem_rd_addr,
  output logic [BM_COL_W-1:0]      bm_col_data_out,
  output logic                     bm_col_data_val,
  output logic                     eng_rstn_o,
  output logic                     cntrl_inbuff_rd_en,
  output logic                     cntrl_eng_calc_en,
  output logic                     cntrl_outbuff_wr_en,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic [31:0]              busy_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ENG_RST, ST_FETCH, ST_WAIT_BM,
    ST_CALC, ST_DRAIN, ST_WRITE, ST_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d, col_q, col_d;
  logic [PKT_CNT_W-1:0]     npkt_q, npkt_d, pkt_q, pkt_d;
  logic [BM_MEM_ADDR_W-1:0] base_q, base_d, addr_q;
  logic [BM_COL_W-1:0]      col_data_q;
  logic                     col_val_q, col_val_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     eng_rstn_q, rd_rq_q, calc_en_q, inbuff_q, outbuff_q;
  logic                     busy_q, done_q;
  logic                     capture, first_col_cycle, abort_hit, cfg_bad;

  assign cfg_bad = (cfg_k == '0) || (cfg_k > K_W'(K_MAX)) || (cfg_num_pkts == '0);

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    npkt_d          = npkt_q;
    base_d          = base_q;
    col_d           = col_q;
    pkt_d           = pkt_q;
    col_val_d       = col_val_q;
    cfg_err_d       = cfg_err_q;
    capture         = 1'b0;
    first_col_cycle = 1'b0;
    abort_hit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d = 1'b0;
            k_d       = cfg_k;
            npkt_d    = cfg_num_pkts;
            base_d    = cfg_bm_base;
            col_d     = '0;
            pkt_d     = '0;
            state_d   = ST_ENG_RST;
          end
        end
      end
      ST_ENG_RST: state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_WAIT_BM;
      ST_WAIT_BM: begin
        if (bm_mem_rd_data_val) begin
          capture         = 1'b1;
          col_val_d       = 1'b1;
          first_col_cycle = 1'b1;
          state_d         = ST_CALC;
        end
      end
      ST_CALC: begin
        if (eng_new_col_req) begin
          col_val_d = 1'b0;
          if (col_q == (k_q - K_W'(1))) begin
            state_d = ST_DRAIN;
          end else begin
            col_d   = col_q + K_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (&eng_empty) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (pkt_q == (npkt_q - PKT_CNT_W'(1))) begin
          state_d = ST_DONE;
        end else begin
          pkt_d   = pkt_q + PKT_CNT_W'(1);
          col_d   = '0;
          state_d = ST_ENG_RST;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the state decided above.
    if ((state_q != ST_IDLE) && abort) begin
      state_d         = ST_IDLE;
      abort_hit       = 1'b1;
      col_val_d       = 1'b0;
      capture         = 1'b0;
      first_col_cycle = 1'b0;
    end
  end

  // Every output is registered from the next state. Each strobe is
  // therefore high in the same cycle as the state it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      npkt_q     <= '0;
      base_q     <= '0;
      col_q      <= '0;
      pkt_q      <= '0;
      col_val_q  <= 1'b0;
      col_data_q <= '0;
      cfg_err_q  <= 1'b0;
      eng_rstn_q <= 1'b0;
      rd_rq_q    <= 1'b0;
      addr_q     <= '0;
      calc_en_q  <= 1'b0;
      inbuff_q   <= 1'b0;
      outbuff_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      npkt_q     <= npkt_d;
      base_q     <= base_d;
      col_q      <= col_d;
      pkt_q      <= pkt_d;
      col_val_q  <= col_val_d;
      cfg_err_q  <= cfg_err_d;
      if (capture) col_data_q <= bm_mem_rd_data;
      eng_rstn_q <= !((state_d == ST_ENG_RST) || abort_hit);
      rd_rq_q    <= (state_d == ST_FETCH);
      // The address uses the next column index because CALC->FETCH advances
      // col_idx on the same edge. Address wrap-around is intentional.
      addr_q     <= (state_d == ST_FETCH) ? (base_q + BM_MEM_ADDR_W'(col_d)) : '0;
      calc_en_q  <= (state_d == ST_CALC);
      inbuff_q   <= first_col_cycle;
      outbuff_q  <= (state_d == ST_WRITE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

`ifdef EC_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_ENG_RST)) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign busy_cycles = perf_q;
`else
  assign busy_cycles = '0;
`endif

  assign bm_mem_rd_rq        = rd_rq_q;
  assign bm_mem_rd_addr      = addr_q;
  assign bm_col_data_out     = col_data_q;
  assign bm_col_data_val     = col_val_q;
  assign eng_rstn_o          = eng_rstn_q;
  assign cntrl_inbuff_rd_en  = inbuff_q;
  assign cntrl_eng_calc_en   = calc_en_q;
  assign cntrl_outbuff_wr_en = outbuff_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign cfg_err             = cfg_err_q;

endmodule
